// File: rtl/jtcontra_dwnld_if.sv
// Download bus bundle: ioctl byte stream in, SDRAM/PROM programming writes out.
// The dwnld_sum member exists only when JTCONTRA_DWNLD_SUM_EN is defined.
interface jtcontra_dwnld_if;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        sdram_ack;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prom_we;
  logic        dwnld_busy;
  logic        overrun;
`ifdef JTCONTRA_DWNLD_SUM_EN
  logic [15:0] dwnld_sum;
`endif

  modport master (
`ifdef JTCONTRA_DWNLD_SUM_EN
    input  dwnld_sum,
`endif
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prom_we,
           dwnld_busy, overrun
  );

  modport slave (
`ifdef JTCONTRA_DWNLD_SUM_EN
    output dwnld_sum,
`endif
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prom_we,
           dwnld_busy, overrun
  );
endinterface

// File: rtl/jtcontra_dwnld.sv
// Routes ioctl download bytes to SDRAM banks or colour PROMs, one-deep pending buffer.
// Optional: JTCONTRA_DWNLD_SUM_EN adds a 16-bit running sum of accepted bytes.
module jtcontra_dwnld (
  input logic             clk,
  input logic             rst,
  jtcontra_dwnld_if.slave bus
);
  localparam logic [24:0] SND_START  = 25'h01_8000;
  localparam logic [24:0] GFX1_START = 25'h02_0000;
  localparam logic [24:0] GFX2_START = 25'h0A_0000;
  localparam logic [24:0] PCM_START  = 25'h12_0000;
  localparam logic [24:0] PROM_START = 25'h12_8000;
  localparam logic [24:0] PROM_END   = 25'h12_8400;
  localparam logic [21:0] PCM_OFFSET = 22'h4000;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic        prom;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic [1:0]  ba;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      pend_q, pend_d, new_s, src_s;
  logic        pend_valid_q, pend_valid_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  mask_q, mask_d, ba_q, ba_d;
  logic        prog_we_q, prog_we_d, prom_we_q, prom_we_d;
  logic        overrun_q, overrun_d, dl_q;
  logic [24:0] base_s, rel_s;
  logic        pcm_s, new_valid_s, free_s, src_valid_s, drop_s, dl_rise_s;

  assign dl_rise_s   = bus.downloading & ~dl_q;
  // A write slot opens when idle or when the presented write is acknowledged.
  assign free_s      = (state_q == IDLE) || bus.sdram_ack;
  assign src_s       = pend_valid_q ? pend_q : new_s;
  assign src_valid_s = free_s && (pend_valid_q || new_valid_s);

  always_comb begin
    base_s      = 25'd0;
    pcm_s       = 1'b0;
    new_s       = '0;
    new_valid_s = bus.ioctl_wr & bus.downloading;
    new_s.data  = bus.ioctl_data;
    new_s.mask  = bus.ioctl_addr[0] ? 2'b01 : 2'b10;
    if (bus.ioctl_addr < SND_START) begin
      base_s = 25'd0;      new_s.ba = 2'd0;
    end else if (bus.ioctl_addr < GFX1_START) begin
      base_s = SND_START;  new_s.ba = 2'd1;
    end else if (bus.ioctl_addr < GFX2_START) begin
      base_s = GFX1_START; new_s.ba = 2'd2;
    end else if (bus.ioctl_addr < PCM_START) begin
      base_s = GFX2_START; new_s.ba = 2'd3;
    end else if (bus.ioctl_addr < PROM_START) begin
      base_s = PCM_START;  new_s.ba = 2'd1; pcm_s = 1'b1;
    end else if (bus.ioctl_addr < PROM_END) begin
      base_s = PROM_START; new_s.ba = 2'd0; new_s.prom = 1'b1;
    end else begin
      base_s = PROM_END;   new_valid_s = 1'b0;
    end
    rel_s = bus.ioctl_addr - base_s;
    if (new_s.prom) begin
      new_s.addr = {12'd0, rel_s[9:0]};
    end else if (pcm_s) begin
      new_s.addr = 22'(rel_s >> 1) + PCM_OFFSET;
    end else begin
      new_s.addr = 22'(rel_s >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (src_valid_s && !src_s.prom) ? BUSY : IDLE;
      BUSY: begin
        if (bus.sdram_ack) state_d = (src_valid_s && !src_s.prom) ? BUSY : IDLE;
        else               state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    ba_d         = ba_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    drop_s       = 1'b0;
    prog_we_d    = (state_d == BUSY);
    if (src_valid_s) begin
      addr_d    = src_s.addr;
      data_d    = src_s.data;
      mask_d    = src_s.mask;
      ba_d      = src_s.ba;
      prom_we_d = src_s.prom;
    end else begin
      prom_we_d = 1'b0;
    end
    // Pending refills from the incoming byte only when its old content moved out.
    if (free_s) begin
      if (pend_valid_q) begin
        pend_valid_d = new_valid_s;
        pend_d       = new_s;
      end else begin
        pend_valid_d = 1'b0;
      end
    end else if (new_valid_s) begin
      if (pend_valid_q) begin
        drop_s = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_d       = new_s;
      end
    end else begin
      pend_valid_d = pend_valid_q;
    end
    overrun_d = (dl_rise_s ? 1'b0 : overrun_q) | drop_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 22'd0; data_q <= 8'd0; mask_q <= 2'd0; ba_q <= 2'd0;
      pend_q <= '0;    pend_valid_q <= 1'b0;
      prog_we_q <= 1'b0; prom_we_q <= 1'b0; overrun_q <= 1'b0; dl_q <= 1'b0;
    end else begin
      addr_q <= addr_d; data_q <= data_d; mask_q <= mask_d; ba_q <= ba_d;
      pend_q <= pend_d; pend_valid_q <= pend_valid_d;
      prog_we_q <= prog_we_d; prom_we_q <= prom_we_d; overrun_q <= overrun_d;
      dl_q <= bus.downloading;
    end
  end

`ifdef JTCONTRA_DWNLD_SUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = (dl_rise_s ? 16'd0 : sum_q)
          + ((new_valid_s && !drop_s) ? {8'd0, bus.ioctl_data} : 16'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= 16'd0;
    else     sum_q <= sum_d;
  end

  assign bus.dwnld_sum = sum_q;
`endif

  assign bus.prog_addr  = addr_q;
  assign bus.prog_data  = {data_q, data_q};
  assign bus.prog_mask  = mask_q;
  assign bus.prog_ba    = ba_q;
  assign bus.prog_we    = prog_we_q;
  assign bus.prom_we    = prom_we_q;
  assign bus.overrun    = overrun_q;
  assign bus.dwnld_busy = bus.downloading | prog_we_q | pend_valid_q | prom_we_q;
endmodule

// File: tb/tb_jtcontra_dwnld.sv
// Directed bench for jtcontra_dwnld: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_jtcontra_dwnld;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  jtcontra_dwnld_if bus();
  jtcontra_dwnld dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    bit          prom;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic [1:0]  ba;
  } item_t;

  // Model state: the write on the SDRAM port, a PROM pulse, and waiting bytes.
  item_t       pq[$];
  bit          m_we = 1'b0, m_prom = 1'b0, m_over = 1'b0, dl_prev = 1'b0;
  logic [21:0] m_addr = 22'd0;
  logic [7:0]  m_data = 8'd0;
  logic [1:0]  m_mask = 2'd0, m_ba = 2'd0;
  logic [15:0] m_sum = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit decode(input logic [24:0] a, input logic [7:0] d, output item_t it);
    int unsigned ai;
    ai      = 32'(a);
    it      = '0;
    it.data = d;
    it.mask = (ai % 2 == 0) ? 2'b10 : 2'b01;
    if      (ai < 32'h18000)  begin it.ba = 2'd0; it.addr = 22'(ai / 2); end
    else if (ai < 32'h20000)  begin it.ba = 2'd1; it.addr = 22'((ai - 32'h18000) / 2); end
    else if (ai < 32'hA0000)  begin it.ba = 2'd2; it.addr = 22'((ai - 32'h20000) / 2); end
    else if (ai < 32'h120000) begin it.ba = 2'd3; it.addr = 22'((ai - 32'hA0000) / 2); end
    else if (ai < 32'h128000) begin it.ba = 2'd1; it.addr = 22'((ai - 32'h120000) / 2 + 32'h4000); end
    else if (ai < 32'h128400) begin it.prom = 1'b1; it.addr = 22'(ai - 32'h128000); end
    else return 1'b0;
    return 1'b1;
  endfunction

  // Reference model, advanced on every active clock edge.
  initial begin
    item_t n, take;
    bit    have_new, got;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_we = 1'b0; m_prom = 1'b0; m_over = 1'b0; dl_prev = 1'b0;
        m_addr = 22'd0; m_data = 8'd0; m_mask = 2'd0; m_ba = 2'd0; m_sum = 16'd0;
        pq.delete();
      end else begin
        if (bus.downloading && !dl_prev) begin m_over = 1'b0; m_sum = 16'd0; end
        dl_prev  = bus.downloading;
        have_new = bus.ioctl_wr && bus.downloading && decode(bus.ioctl_addr, bus.ioctl_data, n);
        m_prom   = 1'b0;
        got      = 1'b0;
        if (!m_we || bus.sdram_ack) begin
          m_we = 1'b0;
          if (pq.size() > 0) begin take = pq.pop_front(); got = 1'b1; end
          else if (have_new) begin take = n; got = 1'b1; have_new = 1'b0; m_sum += 16'(n.data); end
          if (got) begin
            m_addr = take.addr; m_data = take.data; m_mask = take.mask; m_ba = take.ba;
            if (take.prom) m_prom = 1'b1; else m_we = 1'b1;
          end
        end
        if (have_new) begin
          if (pq.size() == 0) begin pq.push_back(n); m_sum += 16'(n.data); end
          else m_over = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("prog_we", 32'(bus.prog_we), 32'(m_we));
      chk("prom_we", 32'(bus.prom_we), 32'(m_prom));
      chk("overrun", 32'(bus.overrun), 32'(m_over));
      chk("busy", 32'(bus.dwnld_busy),
          32'(bus.downloading | m_we | (pq.size() > 0) | m_prom));
      if (m_we) begin
        chk("addr", 32'(bus.prog_addr), 32'(m_addr));
        chk("data", 32'(bus.prog_data), 32'({m_data, m_data}));
        chk("mask", 32'(bus.prog_mask), 32'(m_mask));
        chk("ba",   32'(bus.prog_ba),   32'(m_ba));
      end
      if (m_prom) begin
        chk("prom_addr", 32'(bus.prog_addr[9:0]), 32'(m_addr[9:0]));
        chk("prom_data", 32'(bus.prog_data[3:0]), 32'(m_data[3:0]));
      end
`ifdef JTCONTRA_DWNLD_SUM_EN
      chk("sum", 32'(bus.dwnld_sum), 32'(m_sum));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic chk_sdram(input string nm, input logic [1:0] ba, input logic [21:0] a,
                           input logic [15:0] d, input logic [1:0] m);
    chk({nm, "_we"},   32'(bus.prog_we),   32'd1);
    chk({nm, "_ba"},   32'(bus.prog_ba),   32'(ba));
    chk({nm, "_addr"}, 32'(bus.prog_addr), 32'(a));
    chk({nm, "_data"}, 32'(bus.prog_data), 32'(d));
    chk({nm, "_mask"}, 32'(bus.prog_mask), 32'(m));
  endtask

  // Boundary table: address, data, kind (0 sdram, 1 prom, 2 ignored), bank, word, mask.
  logic [24:0] b_addr [8] = '{25'h01_7FFF, 25'h02_0000, 25'h09_FFFF, 25'h0A_0001,
                              25'h11_FFFF, 25'h12_7FFF, 25'h12_83FF, 25'h12_8400};
  logic [1:0]  b_kind [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
  logic [1:0]  b_ba   [8] = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0};
  logic [21:0] b_word [8] = '{22'h00BFFF, 22'h000000, 22'h03FFFF, 22'h000000,
                              22'h03FFFF, 22'h007FFF, 22'h0003FF, 22'h000000};
  logic [1:0]  b_mask [8] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

  initial begin
    logic [7:0] bd;
    bus.downloading = 1'b0;
    bus.ioctl_addr  = 25'd0;
    bus.ioctl_data  = 8'd0;
    bus.ioctl_wr    = 1'b0;
    bus.sdram_ack   = 1'b0;
    #12;
    chk("rst_we",   32'(bus.prog_we),    32'd0);
    chk("rst_prom", 32'(bus.prom_we),    32'd0);
    chk("rst_addr", 32'(bus.prog_addr),  32'd0);
    chk("rst_data", 32'(bus.prog_data),  32'd0);
    chk("rst_mask", 32'(bus.prog_mask),  32'd0);
    chk("rst_ba",   32'(bus.prog_ba),    32'd0);
    chk("rst_over", 32'(bus.overrun),    32'd0);
    chk("rst_busy", 32'(bus.dwnld_busy), 32'd0);
    tick();
    rst = 1'b0;
    bus.downloading = 1'b1;
    tick();

    // Sound byte with immediate ack: one-cycle prog_we.
    bus.sdram_ack = 1'b1;
    wr_byte(25'h01_8003, 8'h5A);
    chk_sdram("snd", 2'd1, 22'h0001, 16'h5A5A, 2'b01);
    tick();
    chk("snd_we_fall", 32'(bus.prog_we), 32'd0);
    bus.sdram_ack = 1'b0;

    // PROM byte.
    wr_byte(25'h12_8010, 8'h37);
    chk("prom_we",   32'(bus.prom_we),         32'd1);
    chk("prom_addr", 32'(bus.prog_addr[9:0]),  32'h010);
    chk("prom_data", 32'(bus.prog_data[3:0]),  32'h7);
    chk("prom_nowe", 32'(bus.prog_we),         32'd0);
    tick();
    chk("prom_pulse", 32'(bus.prom_we), 32'd0);

    // PCM byte, ack one cycle later.
    wr_byte(25'h12_0002, 8'h11);
    chk_sdram("pcm", 2'd1, 22'h4001, 16'h1111, 2'b10);
    bus.sdram_ack = 1'b1;
    tick();
    chk("pcm_we_fall", 32'(bus.prog_we), 32'd0);

    // Region boundaries with ack held high.
    for (int i = 0; i < 8; i++) begin
      bd = 8'(8'h81 + 8'(i));
      wr_byte(b_addr[i], bd);
      if (b_kind[i] == 2'd0) begin
        chk_sdram("bnd", b_ba[i], b_word[i], {bd, bd}, b_mask[i]);
      end else if (b_kind[i] == 2'd1) begin
        chk("bnd_prom",  32'(bus.prom_we),        32'd1);
        chk("bnd_paddr", 32'(bus.prog_addr[9:0]), 32'(b_word[i][9:0]));
      end else begin
        chk("ign_we",   32'(bus.prog_we), 32'd0);
        chk("ign_prom", 32'(bus.prom_we), 32'd0);
      end
      tick();
    end

    // Strobe ignored while not downloading.
    bus.downloading = 1'b0;
    wr_byte(25'h00_0000, 8'h99);
    chk("nodl_we",   32'(bus.prog_we),    32'd0);
    chk("nodl_busy", 32'(bus.dwnld_busy), 32'd0);
    bus.downloading = 1'b1;
    tick();

    // Strobe and ack together with pending empty: new byte loads directly.
    bus.sdram_ack = 1'b0;
    wr_byte(25'h00_0040, 8'h61);
    bus.sdram_ack = 1'b1;
    wr_byte(25'h00_0041, 8'h62);
    chk_sdram("same", 2'd0, 22'h0020, 16'h6262, 2'b01);
    tick();
    chk("same_fall", 32'(bus.prog_we), 32'd0);
    bus.sdram_ack = 1'b0;

    // Three strobes with ack low: present, pend, drop.
    wr_byte(25'h00_0010, 8'hA1);
    tick();
    wr_byte(25'h00_0011, 8'hB2);
    tick();
    wr_byte(25'h00_0012, 8'hC3);
    chk_sdram("ovr_first", 2'd0, 22'h0008, 16'hA1A1, 2'b10);
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    bus.sdram_ack = 1'b1;
    tick();
    chk_sdram("ovr_second", 2'd0, 22'h0008, 16'hB2B2, 2'b01);
    tick();
    chk("ovr_drain", 32'(bus.prog_we), 32'd0);
    bus.sdram_ack = 1'b0;
    bus.downloading = 1'b0;
    tick();
    chk("idle_busy",   32'(bus.dwnld_busy), 32'd0);
    chk("ovr_sticky",  32'(bus.overrun),    32'd1);
    bus.downloading = 1'b1;
    tick();
    chk("ovr_clear",   32'(bus.overrun),    32'd0);

    // Reset with a write presented and one pending.
    wr_byte(25'h00_0100, 8'h44);
    wr_byte(25'h00_0102, 8'h55);
    #2 rst = 1'b1;
    #1;
    chk("arst_we",   32'(bus.prog_we),   32'd0);
    chk("arst_addr", 32'(bus.prog_addr), 32'd0);
    chk("arst_data", 32'(bus.prog_data), 32'd0);
    chk("arst_mask", 32'(bus.prog_mask), 32'd0);
    chk("arst_ba",   32'(bus.prog_ba),   32'd0);
    tick();
    rst = 1'b0;
    bus.sdram_ack = 1'b1;
    wr_byte(25'h01_8004, 8'h66);
    chk_sdram("post_rst", 2'd1, 22'h0002, 16'h6666, 2'b10);
    tick();
    chk("post_rst_fall", 32'(bus.prog_we), 32'd0);

`ifdef JTCONTRA_DWNLD_SUM_EN
    bus.downloading = 1'b0;
    tick();
    bus.downloading = 1'b1;
    for (int i = 0; i < 257; i++) wr_byte(25'(i), 8'hFF);
    tick();
    chk("sum_ffff", 32'(bus.dwnld_sum), 32'h0000FFFF);
    chk("sum_over", 32'(bus.overrun),   32'd0);
`endif
    bus.sdram_ack = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: run time exceeded 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end
endmodule
